// File: rtl/serial_alu.sv
`timescale 1ns/1ps
// serial_alu
// Bit-serial ALU: operands are consumed LSB first, one bit per clock, through
// a single 1-bit ALU slice. An accepted operation takes WIDTH RUN cycles and
// then raises done for one cycle, with the result and flags loaded together.
//
// Ports:
//   clk        - sole clock, rising edge
//   reset      - asynchronous, active-high reset
//   start      - request to begin an operation (ignored while busy)
//   op_select  - 000 pass B, 010 add, 011 sub A-B, 100 AND, 101 OR, 110 XOR
//   A, B       - operands, sampled on the accepting edge
//   busy       - high during RUN
//   done       - one-cycle pulse when result/flags are valid
//   result     - operation result, held until the next completion
//   negative, zero, overflow, carry_out - status flags of result
module serial_alu #(
  parameter int WIDTH = 64
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       op_select,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             negative,
  output logic             zero,
  output logic             overflow,
  output logic             carry_out
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  localparam logic [2:0] OP_PASS = 3'b000;
  localparam logic [2:0] OP_ADD  = 3'b010;
  localparam logic [2:0] OP_SUB  = 3'b011;
  localparam logic [2:0] OP_AND  = 3'b100;
  localparam logic [2:0] OP_OR   = 3'b101;
  localparam logic [2:0] OP_XOR  = 3'b110;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state, next_state;
  logic [WIDTH-1:0] a_sr, b_sr, res_sr;
  logic [WIDTH-1:0] final_res;
  logic [2:0]       op_reg;
  logic             carry;
  logic [CW-1:0]    count;
  logic             accept, last_bit, is_arith;
  logic             b_eff, alu_bit, carry_next;

  // A new operation can be taken from IDLE or straight out of DONE.
  assign accept   = start && (state == IDLE || state == DONE);
  assign last_bit = (state == RUN) && (count == LAST);
  assign is_arith = (op_reg == OP_ADD) || (op_reg == OP_SUB);

  // The final bit is shifted in on the same edge that loads result, so the
  // completed word is assembled here rather than read back from res_sr.
  assign final_res = {alu_bit, res_sr[WIDTH-1:1]};

  // One-bit ALU slice; subtract is A + ~B with the carry preset to 1.
  always_comb begin
    b_eff      = (op_reg == OP_SUB) ? ~b_sr[0] : b_sr[0];
    carry_next = (a_sr[0] & b_eff) | (a_sr[0] & carry) | (b_eff & carry);
    alu_bit    = 1'b0;
    case (op_reg)
      OP_PASS: alu_bit = b_sr[0];
      OP_ADD,
      OP_SUB:  alu_bit = a_sr[0] ^ b_eff ^ carry;
      OP_AND:  alu_bit = a_sr[0] & b_sr[0];
      OP_OR:   alu_bit = a_sr[0] | b_sr[0];
      OP_XOR:  alu_bit = a_sr[0] ^ b_sr[0];
      default: alu_bit = 1'b0;
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  // Next-state logic.
  always_comb begin
    next_state = state;
    case (state)
      IDLE:    next_state = start ? RUN : IDLE;
      RUN:     next_state = last_bit ? DONE : RUN;
      DONE:    next_state = start ? RUN : IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Status outputs decoded from state.
  always_comb begin
    busy = (state == RUN);
    done = (state == DONE);
  end

  // Operand shift registers, carry flop, bit counter, and the result/flag
  // registers that only change when the last bit is computed.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      a_sr      <= '0;
      b_sr      <= '0;
      res_sr    <= '0;
      op_reg    <= '0;
      carry     <= 1'b0;
      count     <= '0;
      result    <= '0;
      negative  <= 1'b0;
      zero      <= 1'b0;
      overflow  <= 1'b0;
      carry_out <= 1'b0;
    end else if (accept) begin
      a_sr   <= A;
      b_sr   <= B;
      op_reg <= op_select;
      carry  <= (op_select == OP_SUB);
      count  <= '0;
    end else if (state == RUN) begin
      a_sr   <= a_sr >> 1;
      b_sr   <= b_sr >> 1;
      res_sr <= final_res;
      carry  <= carry_next;
      count  <= count + CW'(1);
      if (last_bit) begin
        result    <= final_res;
        negative  <= alu_bit;
        zero      <= (final_res == '0);
        carry_out <= is_arith & carry_next;
        // carry is still the carry into the MSB at this point
        overflow  <= is_arith & (carry ^ carry_next);
      end
    end
  end

endmodule

// File: tb/tb_serial_alu.sv
`timescale 1ns/1ps
// tb_serial_alu
// Directed and back-to-back stimulus for serial_alu (WIDTH=64). Expected
// results come from a word-level arithmetic model and are queued when an
// operation is driven, then popped when done is observed.
module tb_serial_alu;

  localparam int W = 64;

  logic          clk;
  logic          reset;
  logic          start;
  logic [2:0]    op_select;
  logic [W-1:0]  A, B;
  logic          busy, done;
  logic [W-1:0]  result;
  logic          negative, zero, overflow, carry_out;

  typedef struct packed {
    logic [W-1:0] res;
    logic         n;
    logic         z;
    logic         v;
    logic         c;
  } exp_t;

  exp_t          sb[$];
  logic [W-1:0]  last_res;
  int            total;
  int            bad;

  serial_alu #(.WIDTH(W)) dut (
    .clk(clk),
    .reset(reset),
    .start(start),
    .op_select(op_select),
    .A(A),
    .B(B),
    .busy(busy),
    .done(done),
    .result(result),
    .negative(negative),
    .zero(zero),
    .overflow(overflow),
    .carry_out(carry_out)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  // Word-level reference model.
  function automatic exp_t model(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t        e;
    logic [W:0]  full;
    e = '0;
    full = '0;
    case (op)
      3'b000: e.res = b;
      3'b010: begin
        full  = {1'b0, a} + {1'b0, b};
        e.res = full[W-1:0];
        e.c   = full[W];
        e.v   = (a[W-1] == b[W-1]) && (e.res[W-1] != a[W-1]);
      end
      3'b011: begin
        full  = {1'b0, a} + {1'b0, ~b} + 65'd1;
        e.res = full[W-1:0];
        e.c   = full[W];
        e.v   = (a[W-1] != b[W-1]) && (e.res[W-1] != a[W-1]);
      end
      3'b100: e.res = a & b;
      3'b101: e.res = a | b;
      3'b110: e.res = a ^ b;
      default: e.res = '0;
    endcase
    e.n = e.res[W-1];
    e.z = (e.res == '0);
    return e;
  endfunction

  task automatic check_val(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Drive one request at the current negedge; it is accepted on the next
  // posedge, after which the inputs are scrambled to prove they were latched.
  task automatic apply_stimulus(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b, input bit push);
    op_select = op;
    A         = a;
    B         = b;
    start     = 1'b1;
    if (push) sb.push_back(model(op, a, b));
    @(posedge clk);
    #1;
    start     = 1'b0;
    A         = ~a;
    B         = a ^ b;
    op_select = ~op;
  endtask

  task automatic check_output(input string tag);
    exp_t e;
    if (sb.size() == 0) begin
      total++;
      bad++;
      $error("[TB] FAIL %s: scoreboard empty got %h expected an entry", tag, result);
    end else begin
      e = sb.pop_front();
      check_val({tag, " result"}, result, e.res);
      check_val({tag, " negative"}, W'(negative), W'(e.n));
      check_val({tag, " zero"}, W'(zero), W'(e.z));
      check_val({tag, " overflow"}, W'(overflow), W'(e.v));
      check_val({tag, " carry_out"}, W'(carry_out), W'(e.c));
      last_res = e.res;
    end
  endtask

  // Count busy cycles up to done (bounded), optionally pulse start mid-run,
  // then check the pulse width and that result holds afterwards.
  task automatic wait_done(input string tag, input int poke);
    int busy_cycles;
    bit seen;
    busy_cycles = 0;
    seen = 1'b0;
    for (int i = 0; i < 200 && !seen; i++) begin
      @(negedge clk);
      if (done) seen = 1'b1;
      else if (busy) busy_cycles++;
      if (poke >= 0) begin
        start = (i == poke);
        if (i == poke) begin
          A = 64'hFFFF_0000_FFFF_0000;
          B = 64'h1234;
        end
      end
    end
    start = 1'b0;
    check_val({tag, " busy_cycles"}, W'(busy_cycles), W'(W));
    check_val({tag, " done_seen"}, W'(seen), W'(1));
    if (seen) begin
      check_output(tag);
      @(negedge clk);
      check_val({tag, " done_pulse"}, W'(done), W'(0));
      check_val({tag, " hold"}, result, last_res);
    end
  endtask

  initial begin
    int done_count;
    int busy_count;
    total     = 0;
    bad       = 0;
    last_res  = '0;
    clk       = 1'b0;
    reset     = 1'b1;
    start     = 1'b0;
    op_select = 3'b000;
    A         = '0;
    B         = '0;

    repeat (2) @(posedge clk);
    @(negedge clk);
    check_val("rst busy", W'(busy), W'(0));
    check_val("rst done", W'(done), W'(0));
    check_val("rst result", result, '0);
    check_val("rst flags", W'({negative, zero, overflow, carry_out}), W'(0));

    // start at the first edge after reset release
    reset = 1'b0;
    apply_stimulus(3'b010, 64'd5, 64'd3, 1'b1);
    wait_done("add_5_3", -1);

    apply_stimulus(3'b011, 64'd0, 64'd1, 1'b1);
    wait_done("sub_0_1", -1);

    // start pulsed mid-run must be ignored
    apply_stimulus(3'b011, 64'd7, 64'd7, 1'b1);
    wait_done("sub_7_7", 20);

    apply_stimulus(3'b010, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b1);
    wait_done("add_ovf", -1);

    apply_stimulus(3'b110, 64'hDEAD_BEEF, 64'hDEAD_BEEF, 1'b1);
    wait_done("xor_eq", -1);

    apply_stimulus(3'b100, 64'hF0, 64'h3C, 1'b1);
    wait_done("and", -1);

    apply_stimulus(3'b101, 64'hF0, 64'h3C, 1'b1);
    wait_done("or", -1);

    apply_stimulus(3'b000, 64'hF0, 64'h3C, 1'b1);
    wait_done("pass_b", -1);

    // abort an add at RUN cycle 30
    apply_stimulus(3'b010, 64'h1234, 64'h1111, 1'b0);
    repeat (30) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    check_val("abort busy", W'(busy), W'(0));
    check_val("abort done", W'(done), W'(0));
    check_val("abort result", result, '0);
    check_val("abort flags", W'({negative, zero, overflow, carry_out}), W'(0));
    @(negedge clk);
    reset = 1'b0;
    done_count = 0;
    busy_count = 0;
    for (int i = 0; i < 70; i++) begin
      @(negedge clk);
      if (done) done_count++;
      if (busy) busy_count++;
    end
    check_val("abort no_done", W'(done_count), W'(0));
    check_val("abort no_busy", W'(busy_count), W'(0));

    apply_stimulus(3'b010, 64'd2, 64'd2, 1'b1);
    wait_done("add_2_2", -1);

    apply_stimulus(3'b111, 64'hFFFF, 64'h1234, 1'b1);
    wait_done("op_111", -1);

    apply_stimulus(3'b001, 64'hABCD, 64'h5555, 1'b1);
    wait_done("op_001", -1);

    // start held high: an accept every 65 edges, operands changing each cycle
    for (int c = 0; c <= 195; c++) begin
      if (c > 0) begin
        @(negedge clk);
        if (c % 65 == 0) begin
          check_val("b2b done", W'(done), W'(1));
          check_output("b2b");
        end else begin
          check_val("b2b idle_done", W'(done), W'(0));
        end
      end
      if (c < 195) begin
        A         = {$urandom, $urandom};
        B         = {$urandom, $urandom};
        op_select = 3'($urandom_range(0, 7));
        start     = 1'b1;
        if (c % 65 == 0) sb.push_back(model(op_select, A, B));
      end else begin
        start = 1'b0;
      end
    end
    @(negedge clk);
    check_val("b2b final_done", W'(done), W'(0));
    check_val("b2b final_busy", W'(busy), W'(0));
    check_val("sb empty", W'(sb.size()), W'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/serial_alu.md
SERIAL_ALU -- requirements
Module: serial_alu

Interface
REQ-001 SHALL have parameter WIDTH, default 64, operand/result width in bits (legal range 2..64).
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port start  input  1  request to begin an operation.
REQ-005 SHALL have port op_select  input  3  operation code: 000 pass B, 010 add, 011 subtract A-B, 100 AND, 101 OR, 110 XOR; 001/111 illegal.
REQ-006 SHALL have port A  input  WIDTH  first operand.
REQ-007 SHALL have port B  input  WIDTH  second operand.
REQ-008 SHALL have port busy  output  1  high while an operation is in progress.
REQ-009 SHALL have port done  output  1  one-cycle pulse when result and flags are valid.
REQ-010 SHALL have port result  output  WIDTH  operation result.
REQ-011 SHALL have ports negative, zero, overflow, carry_out  output  1 each  status flags of result.

Function
REQ-012 SHALL process operands bit-serially, LSB first, one bit per clock, through a single 1-bit ALU datapath using the same per-bit operation semantics as the parallel ALU slice.
REQ-013 SHALL implement states IDLE, RUN, DONE.
REQ-014 IDLE: start=1 at an edge latches A, B and op_select into internal registers, clears bit counter, enters RUN; start=0 stays IDLE.
REQ-015 RUN: each edge computes bit[counter], shifts it into result shift register, updates carry flop, increments counter; after WIDTH RUN edges enters DONE.
REQ-016 DONE: done=1 for exactly one cycle; next edge returns to IDLE, or directly to RUN (new operands latched) if start=1 in that cycle.
REQ-017 Latency: start sampled at edge k -> done high in the cycle following edge k+WIDTH; busy high from edge k through edge k+WIDTH (RUN cycles only).
REQ-018 start SHALL be ignored while busy=1; latched operands SHALL NOT change during RUN even if A/B/op_select inputs change.
REQ-019 Carry flop initialised at latch: 1 for subtract (011), 0 otherwise; subtract uses inverted B bit.
REQ-020 Illegal op codes SHALL produce result bits of 0 and complete with normal latency.
REQ-021 result and flags SHALL update only when entering DONE and SHALL hold until the next completion.
REQ-022 zero = (result == 0); negative = result[WIDTH-1].
REQ-023 carry_out = final carry out of MSB for add/subtract, 0 for other ops.
REQ-024 overflow = carry into MSB XOR carry out of MSB for add/subtract, 0 for other ops.
REQ-025 Arithmetic SHALL wrap modulo 2^WIDTH; no saturation.

Reset
REQ-026 reset=1 SHALL immediately (asynchronously) force state IDLE, counter 0, busy=0, done=0, result=0, all flags 0.
REQ-027 reset asserted mid-RUN SHALL abort the operation; no done pulse SHALL follow reset release.
REQ-028 start sampled at the first edge after reset release SHALL be accepted normally.

Verification (WIDTH=64)
REQ-029 ADD A=5, B=3, start pulse -> busy 64 cycles, done one cycle later, result=8, all flags 0.
REQ-030 SUB A=0, B=1 -> result=0xFFFF_FFFF_FFFF_FFFF, negative=1, carry_out=0, overflow=0; SUB A=B=7 -> result=0, zero=1, carry_out=1.
REQ-031 ADD A=0x7FFF_FFFF_FFFF_FFFF, B=1 -> result=0x8000_0000_0000_0000, overflow=1, negative=1, carry_out=0.
REQ-032 XOR A=B=0xDEAD_BEEF -> zero=1; AND/OR/pass-B with A=0xF0, B=0x3C -> 0x30 / 0xFC / 0x3C; op 111 -> result=0, zero=1.
REQ-033 start held high continuously with changing operands -> back-to-back ops, each using operands sampled at its own accept edge, done spaced 65 cycles apart.
REQ-034 reset pulsed at RUN cycle 30 -> outputs 0 immediately, no done; fresh ADD 2+2 afterwards -> result=4 with nominal latency.
